aes_encrypt_iter: RTL and testbench
===================================

# aes_encrypt_iter

Iterative, parameterised AES encryption engine: one cipher round per clock, 10/12/14 rounds selected by parameter, with ready/valid handshakes on input and output and optional CBC chaining. It consumes a fully pre-expanded round-key schedule from the existing key-expansion logic. It supersedes the fixed 10-round encryption block in the crypto datapath as the core used by the stream/packet front end.

## Interface
- NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256); any other value is an elaboration error
- KW, 128*(NR+1), derived round-key schedule width; not overridable
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- key  in  KW  expanded schedule. Round key r is key[KW-1-128*r -: 128], so rk0 is the MSBs and equals the cipher key. Must be held stable while busy=1.
- in_valid  in  1  plaintext offered
- in_ready  out  1  engine can accept a block
- data_in  in  128  plaintext; byte 0 = bits [127:120]
- chain_en  in  1  sampled at accept; 1 = XOR chain register into plaintext (CBC)
- iv_load  in  1  load iv into chain register
- iv  in  128  initialisation vector
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- cipher_out  out  128  ciphertext, same byte order as data_in
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: st <= data_in ^ (chain_en ? chain_src : 0) ^ rk0. Set cnt <= 1, latch chain_en into cbc_q, go to ROUND.
- ROUND, one round per cycle:
  - Apply SubBytes, then ShiftRows, then MixColumns, then XOR rk[cnt].
  - When cnt==NR, skip MixColumns, register the result into cipher_out, and go to DONE.
  - Otherwise cnt <= cnt+1.
  - cnt width is 4 bits.
- DONE:
  - out_valid=1; cipher_out is held stable.
  - On out_ready: go to IDLE. If cbc_q=1, chain <= cipher_out.
  - If out_ready=0: remain in DONE indefinitely with data held.
- Chain register:
  - iv_load in IDLE: chain <= iv.
  - iv_load in ROUND or DONE is ignored.
  - chain_src = iv when iv_load and accept occur in the same IDLE cycle; otherwise chain_src = chain.
  - A chain_en=0 block never updates chain.
- S-box: the existing shared S-box function/module, instantiated 16 times combinationally. No MixColumns in the initial AddRoundKey.
- rst in any state:
  - Go to IDLE; any in-flight block is discarded, never emitted.
  - Clear chain, cnt, st, cipher_out and cbc_q to 0.
  - rst has priority over every other input in that cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, cipher_out=0 (from the cycle after the rst edge).
- Latency: accept at edge E0; out_valid rises after edge E_NR. That is NR cycles: 10/12/14.
- Minimum block period: NR+2 cycles with out_ready tied high. in_ready is low from E0 until the edge at which DONE & out_ready is seen.
- in_ready and out_valid are never high in the same cycle.
- Output transfer occurs on the edge where out_valid & out_ready; out_valid falls after that edge.
- in_valid may drop while in_ready=0 without effect. data_in, chain_en and iv are only sampled at accept or load.

## Test plan
- NR=10. key schedule for 000102…0f, data_in 00112233445566778899aabbccddeeff, chain_en=0 → cipher_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- NR=10. key 5468617473206d79204b756e67204675 expanded, data_in 54776f204f6e65204e696e652054776f → 29c3505f571420f6402299b31a02d73a.
- NR=14. key schedule for 000102…1f, data_in 00112233445566778899aabbccddeeff → 8ea2b7ca516745bfeafc49904b496089 after 14 cycles. Repeat with NR=12 and key 000102…17 → dda97ca4864cdfe06eaf70a0ec0d7191.
- CBC, NR=10. key 2b7e151628aed2a6abf7158809cf4f3c; iv_load with iv 000102…0f; two blocks with chain_en=1:
  - 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d
  - ae2d8a571e03ac9c9eb76fac45af8e51 → 5086cb9b507219ee95db113a917678b2
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, cipher_out unchanged, in_ready=0 throughout. Raising out_ready → one transfer, in_ready=1 next cycle.
- Reset mid-operation: assert rst at round 5 → next cycle busy=0, out_valid=0, in_ready=1. No ciphertext is ever emitted for that block; a following chain_en=1 block XORs with chain=0.

Source files
------------

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES encryption core, one round per clock, optional CBC chaining
module aes_encrypt_iter #(
    parameter int NR = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [128*(NR+1)-1:0] i_key,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [127:0]          i_data_in,
    input  logic                  i_chain_en,
    input  logic                  i_iv_load,
    input  logic [127:0]          i_iv,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [127:0]          o_cipher_out,
    output logic                  o_busy
);

    localparam int KW = 128 * (NR + 1);
    localparam logic [3:0] LAST_RND = 4'(NR);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_encrypt_iter: NR must be 10, 12 or 14");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [127:0]   r_st;
    logic [127:0]   r_chain;
    logic [127:0]   r_cipher;
    logic           r_cbc;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;

    logic [127:0]   w_rk [0:NR];
    logic [127:0]   w_sr;
    logic [127:0]   w_mc;
    logic [127:0]   w_next;
    logic [127:0]   w_chain_src;
    logic [127:0]   w_first;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 4c+r is row r of column c; ShiftRows pulls row r from column (c+r) mod 4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign w_rk[r] = i_key[KW - 1 - 128*r -: 128];
    end

    assign w_sr        = sub_shift(r_st);
    assign w_mc        = mix_columns(w_sr);
    assign w_next      = ((r_cnt == LAST_RND) ? w_sr : w_mc) ^ w_rk[r_cnt];
    assign w_chain_src = i_iv_load ? i_iv : r_chain;
    assign w_first     = i_data_in ^ (i_chain_en ? w_chain_src : 128'h0) ^ w_rk[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_st        <= 128'h0;
            r_chain     <= 128'h0;
            r_cipher    <= 128'h0;
            r_cbc       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_iv_load)
                        r_chain <= i_iv;
                    if (i_in_valid) begin
                        r_st       <= w_first;
                        r_cnt      <= 4'd1;
                        r_cbc      <= i_chain_en;
                        r_state    <= S_ROUND;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    if (r_cnt == LAST_RND) begin
                        r_cipher    <= w_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_st  <= w_next;
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        if (r_cbc)
                            r_chain <= r_cipher;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = r_busy;
    assign o_cipher_out = r_cipher;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - random and known-answer bench for aes_encrypt_iter at NR=10/12/14
module tb_aes_encrypt_iter;

    logic           clk = 1'b0;
    logic           rst [3];
    logic           in_valid [3];
    logic           in_ready [3];
    logic [127:0]   data_in [3];
    logic           chain_en [3];
    logic           iv_load [3];
    logic [127:0]   iv [3];
    logic           out_valid [3];
    logic           out_ready [3];
    logic [127:0]   cipher [3];
    logic           busy [3];
    logic [1407:0]  key10;
    logic [1663:0]  key12;
    logic [1919:0]  key14;

    logic [7:0]     sb [0:255];
    logic [1919:0]  msched [3];
    logic [127:0]   mchain [3];
    int             n_vec = 0;
    int             n_bad = 0;

    always #5 clk = ~clk;

    aes_encrypt_iter #(.NR(10)) u_dut10 (
        .i_clk(clk), .i_rst(rst[0]), .i_key(key10), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_data_in(data_in[0]), .i_chain_en(chain_en[0]), .i_iv_load(iv_load[0]), .i_iv(iv[0]),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]), .o_cipher_out(cipher[0]), .o_busy(busy[0]));
    aes_encrypt_iter #(.NR(12)) u_dut12 (
        .i_clk(clk), .i_rst(rst[1]), .i_key(key12), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_data_in(data_in[1]), .i_chain_en(chain_en[1]), .i_iv_load(iv_load[1]), .i_iv(iv[1]),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]), .o_cipher_out(cipher[1]), .o_busy(busy[1]));
    aes_encrypt_iter #(.NR(14)) u_dut14 (
        .i_clk(clk), .i_rst(rst[2]), .i_key(key14), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
        .i_data_in(data_in[2]), .i_chain_en(chain_en[2]), .i_iv_load(iv_load[2]), .i_iv(iv[2]),
        .o_out_valid(out_valid[2]), .i_out_ready(out_ready[2]), .o_cipher_out(cipher[2]), .o_busy(busy[2]));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Standard FIPS-197 key expansion; round key r lands at [1919-128r -: 128].
    function automatic logic [1919:0] expand(input logic [255:0] ck, input int nr);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc [0:14];
        logic [1919:0] sch;
        int            nk;
        nk = nr - 6;
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int j = 2; j < 15; j++) rc[j] = gmul(rc[j-1], 8'h02);
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = ck[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
            else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        sch = '0;
        for (int i = 0; i < 4*(nr+1); i++) sch[1919 - 32*i -: 32] = w[i];
        return sch;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [1919:0] sch, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ sch[1919 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4*c + row] = s[4*((c + row) % 4) + row];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
                    t[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ sch[1919 - 128*r - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_key(input int d, input logic [255:0] ck);
        msched[d] = expand(ck, 10 + 2*d);
        case (d)
            0: key10 = msched[0][1919 -: 1408];
            1: key12 = msched[1][1919 -: 1664];
            default: key14 = msched[2][1919 -: 1920];
        endcase
    endtask

    task automatic load_iv(input int d, input logic [127:0] v);
        iv_load[d] = 1'b1;
        iv[d] = v;
        @(posedge clk); #1;
        iv_load[d] = 1'b0;
        mchain[d] = v;
    endtask

    // One block: accept, count latency, hold in DONE for `hold` cycles, then transfer.
    task automatic do_block(input int d, input logic [127:0] pt, input logic ce, input logic ivl,
                            input logic [127:0] ivv, input int hold, input string tag,
                            input logic use_kat, input logic [127:0] kat);
        logic [127:0] src, exp, got;
        int           cyc;
        src = ivl ? ivv : mchain[d];
        if (ivl) mchain[d] = ivv;
        exp = ref_enc(pt ^ (ce ? src : 128'h0), msched[d], 10 + 2*d);
        check_eq("idle_in_ready", 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1; data_in[d] = pt; chain_en[d] = ce; iv_load[d] = ivl; iv[d] = ivv;
        @(posedge clk); #1;
        in_valid[d] = 1'b0; data_in[d] = rnd128(); chain_en[d] = 1'($urandom);
        cyc = 0;
        while (!out_valid[d] && cyc < 40) begin
            check_eq("busy_in_ready", 128'(in_ready[d]), 128'd0);
            iv_load[d] = 1'($urandom); iv[d] = rnd128();
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("latency", 128'(cyc), 128'(10 + 2*d));
        got = cipher[d];
        check_eq(tag, got, use_kat ? kat : exp);
        for (int h = 0; h < hold; h++) begin
            iv_load[d] = 1'($urandom); iv[d] = rnd128();
            @(posedge clk); #1;
            check_eq("hold_valid", 128'(out_valid[d]), 128'd1);
            check_eq("hold_data", cipher[d], got);
            check_eq("hold_in_ready", 128'(in_ready[d]), 128'd0);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0; iv_load[d] = 1'b0;
        check_eq("xfer_valid_low", 128'(out_valid[d]), 128'd0);
        check_eq("xfer_in_ready", 128'(in_ready[d]), 128'd1);
        if (ce) mchain[d] = exp;
    endtask

    initial begin
        logic [7:0]   inv, b;
        logic [127:0] pt;
        int           seen;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; data_in[d] = '0; chain_en[d] = 1'b0;
            iv_load[d] = 1'b0; iv[d] = '0; out_ready[d] = 1'b0; mchain[d] = '0;
            set_key(d, 256'h0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0;
            check_eq("rst_in_ready", 128'(in_ready[d]), 128'd1);
            check_eq("rst_out_valid", 128'(out_valid[d]), 128'd0);
            check_eq("rst_busy", 128'(busy[d]), 128'd0);
            check_eq("rst_cipher", cipher[d], 128'h0);
        end

        set_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        do_block(0, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, '0, 0, "kat128",
                 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        set_key(0, {128'h5468617473206d79204b756e67204675, 128'h0});
        do_block(0, 128'h54776f204f6e65204e696e652054776f, 1'b0, 1'b0, '0, 0, "kat128b",
                 1'b1, 128'h29c3505f571420f6402299b31a02d73a);
        set_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        do_block(2, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, '0, 0, "kat256",
                 1'b1, 128'h8ea2b7ca516745bfeafc49904b496089);
        set_key(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        do_block(1, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, '0, 0, "kat192",
                 1'b1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);

        set_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        load_iv(0, 128'h000102030405060708090a0b0c0d0e0f);
        do_block(0, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 1'b0, '0, 0, "cbc_blk0",
                 1'b1, 128'h7649abac8119b246cee98e9b12e9197d);
        do_block(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 1'b0, '0, 5, "cbc_blk1",
                 1'b1, 128'h5086cb9b507219ee95db113a917678b2);

        for (int d = 0; d < 3; d++) begin
            set_key(d, {rnd128(), rnd128()});
            for (int n = 0; n < 8; n++)
                do_block(d, rnd128(), 1'($urandom), ($urandom_range(3) == 0), rnd128(),
                         $urandom_range(2), "rand", 1'b0, '0);
        end

        load_iv(0, rnd128());
        in_valid[0] = 1'b1; data_in[0] = rnd128(); chain_en[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0; mchain[0] = '0;
        check_eq("midrst_busy", 128'(busy[0]), 128'd0);
        check_eq("midrst_out_valid", 128'(out_valid[0]), 128'd0);
        check_eq("midrst_in_ready", 128'(in_ready[0]), 128'd1);
        check_eq("midrst_cipher", cipher[0], 128'h0);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            out_ready[0] = 1'b1;
            @(posedge clk); #1;
            if (out_valid[0]) seen++;
        end
        out_ready[0] = 1'b0;
        check_eq("midrst_no_emit", 128'(seen), 128'd0);
        pt = rnd128();
        do_block(0, pt, 1'b1, 1'b0, '0, 0, "post_rst_cbc", 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
